// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard detection and operand-forwarding control for a classic 5-stage
// in-order pipeline (IF, ID, EX, MEM, WB). The block keeps a shadow copy of
// the register-use fields of the instructions currently in EX, MEM and WB.
// It uses those copies to:
//   * pick ALU operand sources (register file, WB result or MEM ALU result),
//   * stall the front end for one cycle on a load-use dependency,
//   * flush IF/ID and bubble ID/EX on a taken branch,
//   * freeze the whole pipeline while a data-memory access is outstanding,
//     and flag a sticky timeout when the freeze lasts too long.
//
// Memory handshake: mem_req is held high by the MEM stage for as long as
// its access is outstanding. The access completes in the cycle where
// mem_req and mem_ready are both high. Every cycle with mem_req=1 and
// mem_ready=0 is a frozen cycle. There is no other transfer condition.
//
// Parameters
//   TIMEOUT          frozen-edge count at which mem_timeout sets
//
// Ports
//   clk              sole clock, rising edge
//   rst_n            asynchronous active-low reset
//   id_rs1/rs2/rd    register fields of the instruction in ID
//   id_valid         ID holds a real instruction
//   id_reg_write     ID instruction writes rd
//   id_mem_read      ID instruction is a load
//   ex_branch_taken  branch/jump resolved taken in EX
//   mem_req          MEM-stage access outstanding
//   mem_ready        MEM-stage access completes this cycle
//   fwd_a_sel        operand A select: 00 regfile, 01 WB, 10 MEM
//   fwd_b_sel        operand B select: 00 regfile, 01 WB, 10 MEM
//   pc_write         PC update enable
//   if_id_write      IF/ID register load enable
//   if_id_flush      IF/ID clear
//   id_ex_bubble     ID/EX clear (inject a bubble)
//   pipe_freeze      hold every pipeline register
//   mem_timeout      sticky memory-wait timeout flag
//   dbg_state        FSM state (0 RUN, 1 MEM_WAIT)
//   dbg_wait_cnt     frozen-edge counter
//   dbg_slot_valid   {WB, MEM, EX} slot valid bits
//   dbg_slot_load    {WB, MEM, EX} slot mem_read bits
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_valid,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_bubble,
  output logic       pipe_freeze,
  output logic       mem_timeout,
  output logic       dbg_state,
  output logic [7:0] dbg_wait_cnt,
  output logic [2:0] dbg_slot_valid,
  output logic [2:0] dbg_slot_load
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // EX slot
  logic       r_ex_valid;
  logic [4:0] r_ex_rd;
  logic [4:0] r_ex_rs1;
  logic [4:0] r_ex_rs2;
  logic       r_ex_rw;
  logic       r_ex_mr;
  // MEM slot
  logic       r_mem_valid;
  logic [4:0] r_mem_rd;
  logic       r_mem_rw;
  logic       r_mem_mr;
  // WB slot
  logic       r_wb_valid;
  logic [4:0] r_wb_rd;
  logic       r_wb_rw;
  logic       r_wb_mr;

  state_t     r_state;
  logic [7:0] r_wait_cnt;
  logic       r_timeout;

  logic       w_freeze;
  logic       w_mem_wr_ok;
  logic       w_wb_wr_ok;
  logic       w_load_use;
  logic       w_bubble;
  logic [7:0] w_cnt_next;

  // -------------------------------------------------------------------------
  // Forwarding
  // -------------------------------------------------------------------------
  // A stage can only forward if it really writes a non-zero register; x0
  // is hard-wired to zero, so a write to it must never be forwarded.
  assign w_mem_wr_ok = r_mem_valid && r_mem_rw && (r_mem_rd != 5'd0);
  assign w_wb_wr_ok  = r_wb_valid  && r_wb_rw  && (r_wb_rd  != 5'd0);

  // MEM is checked first because it holds the younger, more recent value.
  always_comb begin
    fwd_a_sel = SEL_RF;
    fwd_b_sel = SEL_RF;
    if (r_ex_valid) begin
      if (w_mem_wr_ok && (r_mem_rd == r_ex_rs1)) begin
        fwd_a_sel = SEL_MEM;
      end else if (w_wb_wr_ok && (r_wb_rd == r_ex_rs1)) begin
        fwd_a_sel = SEL_WB;
      end
      if (w_mem_wr_ok && (r_mem_rd == r_ex_rs2)) begin
        fwd_b_sel = SEL_MEM;
      end else if (w_wb_wr_ok && (r_wb_rd == r_ex_rs2)) begin
        fwd_b_sel = SEL_WB;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stall / flush / freeze control
  // -------------------------------------------------------------------------
  assign w_freeze    = mem_req && !mem_ready;
  assign pipe_freeze = w_freeze;

  // A load in EX produces its data only at the end of MEM, too late to be
  // forwarded into the dependent instruction's EX cycle, so that
  // instruction has to wait one cycle in ID.
  assign w_load_use = !w_freeze && !ex_branch_taken &&
                      r_ex_valid && r_ex_mr && (r_ex_rd != 5'd0) &&
                      id_valid &&
                      ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));

  // Priority: freeze, then branch, then load-use. While in reset the front
  // end is left free-running with no flush or bubble.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (rst_n) begin
      if (w_freeze) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (w_load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  assign w_bubble = id_ex_bubble;

  // -------------------------------------------------------------------------
  // Slot pipeline: shifts on every unfrozen edge
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd     <= 5'd0;
      r_ex_rs1    <= 5'd0;
      r_ex_rs2    <= 5'd0;
      r_ex_rw     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_rd    <= 5'd0;
      r_mem_rw    <= 1'b0;
      r_mem_mr    <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_rw     <= 1'b0;
      r_wb_mr     <= 1'b0;
    end else if (!w_freeze) begin
      if (id_valid && !w_bubble) begin
        r_ex_valid <= 1'b1;
        r_ex_rd    <= id_rd;
        r_ex_rs1   <= id_rs1;
        r_ex_rs2   <= id_rs2;
        r_ex_rw    <= id_reg_write;
        r_ex_mr    <= id_mem_read;
      end else begin
        // Bubbles carry all-zero fields so they can never match anything.
        r_ex_valid <= 1'b0;
        r_ex_rd    <= 5'd0;
        r_ex_rs1   <= 5'd0;
        r_ex_rs2   <= 5'd0;
        r_ex_rw    <= 1'b0;
        r_ex_mr    <= 1'b0;
      end
      r_mem_valid <= r_ex_valid;
      r_mem_rd    <= r_ex_rd;
      r_mem_rw    <= r_ex_rw;
      r_mem_mr    <= r_ex_mr;
      r_wb_valid  <= r_mem_valid;
      r_wb_rd     <= r_mem_rd;
      r_wb_rw     <= r_mem_rw;
      r_wb_mr     <= r_mem_mr;
    end
  end

  // -------------------------------------------------------------------------
  // Memory-wait FSM, wait counter and sticky timeout
  // -------------------------------------------------------------------------
  // The counter counts every frozen edge, including the one that leaves
  // RUN, and clears on any unfrozen edge, so it is zero whenever the FSM
  // sits in RUN.
  assign w_cnt_next = (r_wait_cnt == 8'hFF) ? r_wait_cnt : (r_wait_cnt + 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_freeze) begin
            r_state <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (!w_freeze) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase

      if (w_freeze) begin
        r_wait_cnt <= w_cnt_next;
        if (32'(w_cnt_next) == TIMEOUT) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_wait_cnt <= 8'd0;
      end
    end
  end

  assign mem_timeout    = r_timeout;
  assign dbg_state      = r_state;
  assign dbg_wait_cnt   = r_wait_cnt;
  assign dbg_slot_valid = {r_wb_valid, r_mem_valid, r_ex_valid};
  assign dbg_slot_load  = {r_wb_mr, r_mem_mr, r_ex_mr};

endmodule
